// File: rtl/vga_sprite_pkg.sv
// ============================================================================
// vga_sprite_pkg : register map, bit positions and swap-state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_sprite_pkg;

  localparam logic REG_CTRL   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int CTRL_SWAP_BIT   = 0;
  localparam int CTRL_IRQEN_BIT  = 1;
  localparam int CTRL_IRQCLR_BIT = 2;

  localparam int STAT_PEND_BIT  = 0;
  localparam int STAT_FRONT_BIT = 1;
  localparam int STAT_FLAG_BIT  = 2;
  localparam int STAT_IRQEN_BIT = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

endpackage

`default_nettype wire

// File: rtl/sprite_page_ram.sv
// ============================================================================
// sprite_page_ram : two-page sprite store, byte-writable port A, read port B
// Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_page_ram #(
  parameter int    DW        = 32,
  parameter int    AW        = 11,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            a_en_i,
  input  logic            a_we_i,
  input  logic [DW/8-1:0] a_be_i,
  input  logic [AW-1:0]   a_addr_i,
  input  logic [DW-1:0]   a_wdata_i,
  output logic [DW-1:0]   a_rdata_o,
  input  logic            b_en_i,
  input  logic [AW-1:0]   b_addr_i,
  output logic [DW-1:0]   b_rdata_o
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  // One byte-wide array per lane keeps byte enables a plain write enable.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] a_q;
    logic [7:0] b_q;

    always_ff @(posedge clk) begin
      if (a_we_i && a_be_i[gi]) mem_q[a_addr_i] <= a_wdata_i[gi*8 +: 8];
      if (a_en_i) a_q <= mem_q[a_addr_i];
    end

    always_ff @(posedge clk) begin
      if (b_en_i) b_q <= mem_q[b_addr_i];
    end

    assign a_rdata_o[gi*8 +: 8] = a_q;
    assign b_rdata_o[gi*8 +: 8] = b_q;
  end

endmodule

`default_nettype wire

// File: rtl/vga_sprite_dbuf.sv
// ============================================================================
// vga_sprite_dbuf : double-buffered sprite memory, frame-synchronous swap
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_sprite_dbuf
  import vga_sprite_pkg::*;
#(
  parameter int    CPU_DW      = 32,
  parameter int    PIX_DW      = 16,
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS),
  localparam int   RATIO       = CPU_DW / PIX_DW,
  localparam int   LW          = $clog2(RATIO),
  localparam int   PAW         = AW + LW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                avs_chipselect,
  input  logic [AW:0]         avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [CPU_DW/8-1:0] avs_byteenable,
  input  logic [CPU_DW-1:0]   avs_writedata,
  output logic [CPU_DW-1:0]   avs_readdata,
  input  logic                pix_req,
  input  logic [PAW-1:0]      pix_addr,
  output logic                pix_valid,
  output logic [PIX_DW-1:0]   pix_data,
  input  logic                frame_start,
  output logic                irq
);

  swap_state_e         state_q;
  logic                front_q;
  logic                irq_flag_q;
  logic                irq_en_q;
  logic                rd_mem_q;
  logic [CPU_DW-1:0]   reg_rdata_q;
  logic [CPU_DW-1:0]   reg_rdata_d;
  logic                pix_valid_q;

  logic                cpu_rd;
  logic                cpu_wr;
  logic                reg_sel;
  logic                ctrl_wr;
  logic                swap_req;
  logic [CPU_DW-1:0]   ram_a_rdata;
  logic [CPU_DW-1:0]   ram_b_rdata;
  logic [PIX_DW-1:0]   pix_lane;

  assign cpu_rd   = avs_chipselect && avs_read;
  assign cpu_wr   = avs_chipselect && avs_write;
  assign reg_sel  = avs_address[AW];
  assign ctrl_wr  = cpu_wr && reg_sel && (avs_address[0] == REG_CTRL);
  assign swap_req = ctrl_wr && avs_writedata[CTRL_SWAP_BIT];

  sprite_page_ram #(
    .DW        (CPU_DW),
    .AW        (AW + 1),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk       (clk),
    .a_en_i    (cpu_rd && !reg_sel),
    .a_we_i    (cpu_wr && !reg_sel),
    .a_be_i    (avs_byteenable),
    .a_addr_i  ({~front_q, avs_address[AW-1:0]}),
    .a_wdata_i (avs_writedata),
    .a_rdata_o (ram_a_rdata),
    .b_en_i    (pix_req),
    .b_addr_i  ({front_q, pix_addr[PAW-1:LW]}),
    .b_rdata_o (ram_b_rdata)
  );

  // Clear is applied before the swap branch so a coincident completion wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      front_q    <= 1'b0;
      irq_flag_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= avs_writedata[CTRL_IRQEN_BIT];
      if (ctrl_wr && avs_writedata[CTRL_IRQCLR_BIT]) irq_flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (swap_req) state_q <= PENDING;
        end
        PENDING: begin
          if (frame_start) begin
            front_q    <= ~front_q;
            irq_flag_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    reg_rdata_d = '0;
    case (avs_address[0])
      REG_CTRL: begin
        reg_rdata_d[CTRL_IRQEN_BIT] = irq_en_q;
      end
      REG_STATUS: begin
        reg_rdata_d[STAT_PEND_BIT]  = (state_q == PENDING);
        reg_rdata_d[STAT_FRONT_BIT] = front_q;
        reg_rdata_d[STAT_FLAG_BIT]  = irq_flag_q;
        reg_rdata_d[STAT_IRQEN_BIT] = irq_en_q;
      end
      default: ;
    endcase
  end

  // Read data holds until the next read: both sources only load on a read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_mem_q    <= 1'b0;
      reg_rdata_q <= '0;
    end else if (cpu_rd) begin
      rd_mem_q <= !reg_sel;
      if (reg_sel) reg_rdata_q <= reg_rdata_d;
    end
  end

  assign avs_readdata = rd_mem_q ? ram_a_rdata : reg_rdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) pix_valid_q <= 1'b0;
    else          pix_valid_q <= pix_req;
  end

  if (LW > 0) begin : g_lane_mux
    logic [LW-1:0] lane_q;
    always_ff @(posedge clk) begin
      if (!reset_n)    lane_q <= '0;
      else if (pix_req) lane_q <= pix_addr[LW-1:0];
    end
    assign pix_lane = ram_b_rdata[lane_q*PIX_DW +: PIX_DW];
  end else begin : g_no_lane_mux
    assign pix_lane = ram_b_rdata[PIX_DW-1:0];
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_valid_q ? pix_lane : '0;
  assign irq       = irq_flag_q && irq_en_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sprite_dbuf.sv
// ============================================================================
// tb_vga_sprite_dbuf : directed + randomized bench with a page-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_sprite_dbuf;

  localparam int CPU_DW = 32;
  localparam int PIX_DW = 16;
  localparam int DEPTH  = 1024;
  localparam int AW     = 10;
  localparam int PAW    = 11;
  localparam logic [AW:0] A_CTRL   = 11'h400;
  localparam logic [AW:0] A_STATUS = 11'h401;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              avs_chipselect;
  logic [AW:0]       avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [3:0]        avs_byteenable;
  logic [CPU_DW-1:0] avs_writedata;
  logic [CPU_DW-1:0] avs_readdata;
  logic              pix_req;
  logic [PAW-1:0]    pix_addr;
  logic              pix_valid;
  logic [PIX_DW-1:0] pix_data;
  logic              frame_start;
  logic              irq;

  always #5 clk = ~clk;

  vga_sprite_dbuf dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_chipselect (avs_chipselect),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_byteenable (avs_byteenable),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .pix_req        (pix_req),
    .pix_addr       (pix_addr),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .frame_start    (frame_start),
    .irq            (irq)
  );

  // Reference model: two pages of words, a front index and a pending flag.
  logic [31:0] m_mem   [2*DEPTH];
  bit          m_known [2*DEPTH];
  bit          m_front, m_pend, m_flag, m_en;
  logic [31:0] e_rdata;
  bit          e_rd_known;
  bit          e_pvalid;
  bit          e_pknown;
  logic [15:0] e_pdata;
  int          n_vec;
  int          n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    avs_chipselect = 1'b0;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_byteenable = '0;
    avs_writedata  = '0;
    pix_req        = 1'b0;
    pix_addr       = '0;
    frame_start    = 1'b0;
  endtask

  task automatic tick();
    int          w;
    logic [31:0] word;
    bit          ctrl_wr, swapped;
    @(posedge clk);
    if (!reset_n) begin
      m_front = 0; m_pend = 0; m_flag = 0; m_en = 0;
      e_rdata = '0; e_rd_known = 1; e_pvalid = 0;
    end else begin
      e_pvalid = pix_req;
      if (pix_req) begin
        w        = int'(m_front) * DEPTH + int'(pix_addr) / 2;
        word     = m_mem[w];
        e_pknown = m_known[w];
        e_pdata  = 16'(word >> (PIX_DW * (int'(pix_addr) % 2)));
      end
      if (avs_chipselect && avs_read) begin
        if (avs_address[AW]) begin
          e_rd_known = 1;
          if (avs_address[0]) e_rdata = 32'(m_en) * 8 + 32'(m_flag) * 4 + 32'(m_front) * 2 + 32'(m_pend);
          else                e_rdata = 32'(m_en) * 2;
        end else begin
          w          = (1 - int'(m_front)) * DEPTH + int'(avs_address[AW-1:0]);
          e_rdata    = m_mem[w];
          e_rd_known = m_known[w];
        end
      end
      if (avs_chipselect && avs_write && !avs_address[AW]) begin
        w = (1 - int'(m_front)) * DEPTH + int'(avs_address[AW-1:0]);
        for (int i = 0; i < 4; i++)
          if (avs_byteenable[i]) m_mem[w][8*i +: 8] = avs_writedata[8*i +: 8];
        if (avs_byteenable == 4'hF) m_known[w] = 1;
      end
      ctrl_wr = avs_chipselect && avs_write && avs_address[AW] && !avs_address[0];
      swapped = 0;
      if (m_pend && frame_start) begin
        m_front = !m_front; m_pend = 0; swapped = 1;
      end else if (!m_pend && ctrl_wr && avs_writedata[0]) begin
        m_pend = 1;
      end
      if (swapped) m_flag = 1;
      else if (ctrl_wr && avs_writedata[2]) m_flag = 0;
      if (ctrl_wr) m_en = avs_writedata[1];
    end
    @(negedge clk);
    check_eq("irq", 32'(irq), 32'(m_flag && m_en));
    check_eq("pix_valid", 32'(pix_valid), 32'(e_pvalid));
    if (e_pvalid && e_pknown) check_eq("pix_data", 32'(pix_data), 32'(e_pdata));
    if (e_rd_known) check_eq("readdata", avs_readdata, e_rdata);
    idle_inputs();
  endtask

  task automatic wr(input logic [AW:0] a, input logic [3:0] be, input logic [31:0] d);
    avs_chipselect = 1'b1; avs_write = 1'b1;
    avs_address = a; avs_byteenable = be; avs_writedata = d;
    tick();
  endtask

  task automatic rd(input logic [AW:0] a);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
  endtask

  task automatic pix(input logic [PAW-1:0] a);
    pix_req = 1'b1; pix_addr = a;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    n_vec = 0; n_err = 0;
    m_front = 0; m_pend = 0; m_flag = 0; m_en = 0;
    e_rdata = '0; e_rd_known = 1; e_pvalid = 0; e_pknown = 0; e_pdata = '0;
    for (int i = 0; i < 2*DEPTH; i++) m_known[i] = 0;
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_pix_valid", 32'(pix_valid), 32'h0);
    check_eq("rst_readdata", avs_readdata, 32'h0);

    rd(A_STATUS); check_eq("status_rst", avs_readdata, 32'h0);
    rd(A_CTRL);   check_eq("ctrl_rst", avs_readdata, 32'h0);

    wr(11'd5, 4'hF, 32'hDEADBEEF);
    wr(11'd5, 4'b0101, 32'h11223344);
    rd(11'd5);    check_eq("byteenable_merge", avs_readdata, 32'hDE22BE44);

    wr(11'd0, 4'hF, 32'hAAAA5555);
    wr(A_CTRL, 4'hF, 32'h1);
    rd(A_STATUS); check_eq("swap_pending", avs_readdata, 32'h1);
    frame();
    rd(A_STATUS); check_eq("swap_done", avs_readdata, 32'h6);
    pix(11'd0);
    check_eq("pix_valid_lane0", 32'(pix_valid), 32'h1);
    check_eq("pix_lane0", 32'(pix_data), 32'h5555);
    pix(11'd1);
    check_eq("pix_lane1", 32'(pix_data), 32'hAAAA);

    wr(A_CTRL, 4'hF, 32'h4);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = A_CTRL;
    avs_byteenable = 4'hF; avs_writedata = 32'h1; frame_start = 1'b1;
    tick();
    rd(A_STATUS); check_eq("same_cycle_req_frame", avs_readdata, 32'h3);
    frame();
    rd(A_STATUS); check_eq("deferred_swap", avs_readdata, 32'h4);

    wr(A_CTRL, 4'hF, 32'h4);
    wr(A_CTRL, 4'hF, 32'h2);
    check_eq("irq_enabled_no_flag", 32'(irq), 32'h0);
    wr(A_CTRL, 4'hF, 32'h3);
    frame();
    check_eq("irq_on_swap", 32'(irq), 32'h1);
    wr(A_CTRL, 4'hF, 32'h6);
    check_eq("irq_cleared", 32'(irq), 32'h0);
    wr(A_CTRL, 4'hF, 32'h3);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = A_CTRL;
    avs_byteenable = 4'hF; avs_writedata = 32'h6; frame_start = 1'b1;
    tick();
    check_eq("irq_set_beats_clear", 32'(irq), 32'h1);

    wr(A_CTRL, 4'hF, 32'h1);
    rd(A_STATUS); check_eq("pending_before_reset", avs_readdata, 32'h5);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    rd(A_STATUS); check_eq("reset_drops_pending", avs_readdata, 32'h0);
    frame();
    rd(A_STATUS); check_eq("no_swap_after_reset", avs_readdata, 32'h0);

    for (int i = 0; i < 32; i++) wr(11'(i), 4'hF, $urandom);
    wr(A_CTRL, 4'hF, 32'h1);
    frame();
    for (int i = 0; i < 32; i++) wr(11'(i), 4'hF, $urandom);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        continue;
      end
      op = $urandom_range(0, 3);
      avs_chipselect = ($urandom_range(0, 7) != 0);
      case (op)
        1: begin
          avs_write = 1'b1; avs_address = 11'($urandom_range(0, 31));
          avs_byteenable = 4'($urandom); avs_writedata = $urandom;
        end
        2: begin
          avs_read = 1'b1;
          avs_address = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 31))
                      : (($urandom_range(0, 1) == 0) ? A_CTRL : A_STATUS);
        end
        3: begin
          avs_write = 1'b1; avs_byteenable = 4'hF;
          avs_address = ($urandom_range(0, 5) == 0) ? A_STATUS : A_CTRL;
          avs_writedata = 32'($urandom_range(0, 7));
        end
        default: ;
      endcase
      pix_req     = 1'($urandom_range(0, 1));
      pix_addr    = 11'($urandom_range(0, 63));
      frame_start = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
